// File: rtl/sipo_deserializer_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
package sipo_deserializer_pkg;

    // Default word length in bits.
    localparam int unsigned SIPO_DEFAULT_WIDTH = 4;

    // Width of the bit counter: enough to count 0..width-1, never narrower than 1.
    function automatic int unsigned sipo_cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned SIPO_DEFAULT_CNT_W = sipo_cnt_width(SIPO_DEFAULT_WIDTH);

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts accepted bits of the current word, wraps on the last bit and
// flags word completion on that same edge. A clear aborts the word.
module sipo_bit_counter
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = sipo_cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Completion: the bit being accepted now is the last one of the word.
    assign done_o = inc_i && !clr_i && (count_q == LAST);

    // Next count: clear dominates, then wrap on completion, else increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with a one-word holding register,
// valid/ready handshake and a sticky overrun flag for dropped words.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              serial_in,
    input  logic                              shift_en,
    input  logic                              flush,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  parallel_out,
    output logic                              out_valid,
    output logic                              overrun,
    output logic [sipo_cnt_width(WIDTH)-1:0]  bit_count
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] hold_q;
    logic             valid_q;
    logic             ovr_q;
    logic             word_done;

    sipo_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (sipo_cnt_width(WIDTH))
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (shift_en),
        .clr_i   (flush),
        .count_o (bit_count),
        .done_o  (word_done)
    );

    // Shift register contents after accepting serial_in; on completion this
    // is the finished word, so the final bit is part of what gets loaded.
    always_comb begin
        sreg_d = sreg_q;
        if (MSB_FIRST) begin
            sreg_d = {sreg_q[WIDTH-2:0], serial_in};
        end else begin
            sreg_d = {serial_in, sreg_q[WIDTH-1:1]};
        end
    end

    // Shift register: flush discards the partial word and wins over shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
        end else if (flush) begin
            sreg_q <= '0;
        end else if (shift_en) begin
            sreg_q <= sreg_d;
        end
    end

    // Holding register and handshake: load when empty or being consumed,
    // otherwise drop the new word and latch overrun until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (word_done) begin
            if (!valid_q || out_ready) begin
                hold_q  <= sreg_d;
                valid_q <= 1'b1;
            end else begin
                ovr_q <= 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign parallel_out = hold_q;
    assign out_valid    = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus
// and are compared against a queue-based word model after every edge.
module tb_sipo_deserializer;

    localparam int unsigned W = 4;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       shift_en;
    logic       flush;
    logic       out_ready;
    logic [3:0] p_m;
    logic [3:0] p_l;
    logic       v_m, v_l;
    logic       o_m, o_l;
    logic [1:0] c_m, c_l;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    bit         m_bits[$];
    logic [3:0] m_hold_m;
    logic [3:0] m_hold_l;
    bit         m_valid;
    bit         m_ovr;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
        .flush(flush), .out_ready(out_ready), .parallel_out(p_m),
        .out_valid(v_m), .overrun(o_m), .bit_count(c_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
        .flush(flush), .out_ready(out_ready), .parallel_out(p_l),
        .out_valid(v_l), .overrun(o_l), .bit_count(c_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_hold_m = '0;
        m_hold_l = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
    endtask

    // One clock edge of the specified behaviour, in terms of received bits.
    task automatic model_edge(input bit sin, input bit sen, input bit fl, input bit rdy);
        bit         done;
        bit         consume;
        logic [3:0] wm;
        logic [3:0] wl;
        done    = 1'b0;
        consume = m_valid && rdy;
        wm      = '0;
        wl      = '0;
        if (fl) begin
            m_bits.delete();
        end else if (sen) begin
            m_bits.push_back(sin);
            if (m_bits.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < int'(W); i++) begin
                    wm[W-1-i] = m_bits[i];
                    wl[i]     = m_bits[i];
                end
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_hold_m = wm;
                m_hold_l = wl;
                m_valid  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (consume) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("msb.parallel_out", 32'(p_m), 32'(m_hold_m));
        chk("msb.out_valid",    32'(v_m), 32'(m_valid));
        chk("msb.overrun",      32'(o_m), 32'(m_ovr));
        chk("msb.bit_count",    32'(c_m), 32'(m_bits.size()));
        chk("lsb.parallel_out", 32'(p_l), 32'(m_hold_l));
        chk("lsb.out_valid",    32'(v_l), 32'(m_valid));
        chk("lsb.overrun",      32'(o_l), 32'(m_ovr));
        chk("lsb.bit_count",    32'(c_l), 32'(m_bits.size()));
    endtask

    // Drive inputs, take one edge, update the model, then check 1 time unit later.
    task automatic tick(input bit sin, input bit sen, input bit fl, input bit rdy);
        serial_in = sin;
        shift_en  = sen;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        model_edge(sin, sen, fl, rdy);
        #1;
        check_all();
    endtask

    // Send a 4-bit word in order w[3], w[2], w[1], w[0] on consecutive edges.
    task automatic send_word(input logic [3:0] w, input bit rdy_mid, input bit rdy_last);
        for (int i = 3; i >= 0; i--) begin
            tick(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_mid);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] p2s;
        rst       = 1'b0;
        serial_in = 1'b0;
        shift_en  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check_all();
        chk("reset.msb.out_valid", 32'(v_m), 32'd0);
        #9;
        rst = 1'b1;

        // 1,0,1,1 with consumer ready: valid for one cycle
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(4'b1011, 1'b1, 1'b1);
        chk("b1011.msb.word",  32'(p_m), 32'hB);
        chk("b1011.lsb.word",  32'(p_l), 32'hD);
        chk("b1011.valid",     32'(v_m), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b1011.valid_drop", 32'(v_m), 32'd0);

        // Loopback from a parallel-to-serial shifter loaded with A
        p2s = 4'hA;
        for (int i = 0; i < 4; i++) begin
            tick(p2s[3], 1'b1, 1'b0, 1'b0);
            p2s = {p2s[2:0], 1'b0};
        end
        chk("loopback.word", 32'(p_m), 32'hA);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: 3 then 5 with consumer stalled
        send_word(4'h3, 1'b0, 1'b0);
        send_word(4'h5, 1'b0, 1'b0);
        chk("ovr.held_word", 32'(p_m), 32'h3);
        chk("ovr.flag",      32'(o_m), 32'd1);
        // 6 completes on the same edge the held 3 is consumed
        send_word(4'h6, 1'b0, 1'b1);
        chk("ovr.reload", 32'(p_m), 32'h6);
        chk("ovr.valid",  32'(v_m), 32'd1);
        chk("ovr.sticky", 32'(o_m), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Flush with a simultaneous shift, then a clean word
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush.pre_count", 32'(c_m), 32'd2);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush.count", 32'(c_m), 32'd0);
        send_word(4'h9, 1'b1, 1'b1);
        chk("flush.word",   32'(p_m), 32'h9);
        chk("flush.sticky", 32'(o_m), 32'd1);

        // Async reset mid-word with a held word
        send_word(4'h7, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst.pre_count", 32'(c_m), 32'd2);
        chk("rst.pre_valid", 32'(v_m), 32'd1);
        reset_pulse();
        chk("rst.word",    32'(p_m), 32'd0);
        chk("rst.overrun", 32'(o_m), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.no_word", 32'(v_m), 32'd0);
        send_word(4'hC, 1'b1, 1'b1);
        chk("rst.after_word", 32'(p_m), 32'hC);

        // Random traffic with gaps, stalls, flushes and occasional resets
        for (int n = 0; n < 500; n++) begin
            tick(1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 79) == 0) begin
                reset_pulse();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 4: word length in bits; legal values 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first bit lands in parallel_out[0].
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port serial_in, input, 1: serial data bit, sampled only when shift_en=1.
REQ-006 Port shift_en, input, 1: bit-valid strobe; one bit is accepted per clk edge while high.
REQ-007 Port flush, input, 1: synchronous abort of a partially received word.
REQ-008 Port out_ready, input, 1: consumer accepts the held word.
REQ-009 Port parallel_out, output, WIDTH: assembled word from the holding register.
REQ-010 Port out_valid, output, 1: holding register contains an unconsumed word.
REQ-011 Port overrun, output, 1: sticky error flag; a completed word was dropped.
REQ-012 Port bit_count, output, clog2(WIDTH): number of bits accepted into the current partial word.

Function
REQ-013 Each edge with shift_en=1 and flush=0 shall shift serial_in into the internal shift register and increment bit_count.
REQ-014 When MSB_FIRST=1, shifting shall be {sreg[WIDTH-2:0], serial_in}; otherwise {serial_in, sreg[WIDTH-1:1]}.
REQ-015 The WIDTH-th accepted bit shall complete the word: bit_count wraps to 0 on the same edge.
REQ-016 The completed word shall include that final bit in its assembly.
REQ-017 Latency from the final bit's edge to out_valid=1 with the word on parallel_out shall be exactly one clk edge; out_valid is high in the following cycle.
REQ-018 Handshake: a word is consumed on an edge where out_valid=1 and out_ready=1; out_valid then drops unless a new word completes on that edge.
REQ-019 parallel_out shall hold stable while out_valid=1 and out_ready=0.
REQ-020 Completion with the holding register empty, or with out_ready=1 on that edge, shall load the new word and set out_valid=1; overrun is not set.
REQ-021 Completion with out_valid=1 and out_ready=0 shall drop the new word, keep the held word, and set overrun=1.
REQ-022 overrun shall stay set until reset; flush shall not clear it.
REQ-023 flush=1 shall clear bit_count and the shift register, discarding the partial word.
REQ-024 flush shall take priority over a simultaneous shift_en.
REQ-025 flush shall not affect out_valid, parallel_out or the handshake.
REQ-026 shift_en=0 shall hold bit_count and the shift register indefinitely; gaps between bits are legal.
REQ-027 parallel_out shall be a registered output with no combinational path from serial_in.
REQ-028 out_valid shall be a registered output with no combinational path from serial_in.

Reset
REQ-029 rst=0 shall asynchronously force parallel_out=0, out_valid=0, overrun=0, bit_count=0 and the shift register to 0.
REQ-030 On release, the first accepted bit shall be bit 0 of a new word.
REQ-031 Reset asserted mid-word or with a held word shall discard all data; no word is output after release.

Structure
REQ-032 The default WIDTH constant shall live in the shared project package.
REQ-033 The clog2-based count width shall live in the shared project package.
REQ-034 The bit counter (count, wrap and completion pulse, with flush clear) shall be one sub-module named sipo_bit_counter.
REQ-035 The shift register, holding register and handshake logic shall reside in sipo_deserializer.

Verification
REQ-036 WIDTH=4, MSB_FIRST=1: shift 1,0,1,1 on consecutive edges, out_ready=1 -> out_valid=1 for one cycle, one edge after the 4th bit, with parallel_out=4'b1011.
REQ-037 MSB_FIRST=0: same bits -> parallel_out=4'b1101.
REQ-038 Loopback from the existing parallel-to-serial shifter loaded with 4'hA -> parallel_out=4'hA.
REQ-039 out_ready=0, shift 4'h3 then 4'h5 -> parallel_out stays 4'h3 and overrun=1.
REQ-040 Continuing REQ-039, raise out_ready=1 on the edge 4'h6 completes -> 4'h3 consumed, 4'h6 loaded, no further overrun change.
REQ-041 Shift 2 bits, flush=1 together with shift_en=1, then shift 4'h9 -> bit_count=0 after flush and parallel_out=4'h9.
REQ-042 Assert rst=0 asynchronously mid-word (bit_count=2, out_valid=1) -> all outputs 0 immediately; the next 4 bits 4'hC produce parallel_out=4'hC.
